// File: rtl/aes_key_pack_pkg.sv
// Shared types for the byte-serial AES key loader: key length, packed key word and loader states.
package aes_key_pack_pkg;

  localparam int Nk = 4;

  typedef logic [32*Nk-1:0] key_word_t;

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    FULL
  } key_pack_state_t;

endpackage

// File: rtl/aes_key_pack_if.sv
// Byte-stream input and packed-key output handshakes of the key loader.
interface aes_key_pack_if #(
  parameter int NK = aes_key_pack_pkg::Nk
);

  logic            byte_valid;
  logic [7:0]      byte_data;
  logic            byte_last;
  logic            byte_ready;
  logic            clear;
  logic            key_valid;
  logic            key_ready;
  logic [32*NK-1:0] key_out;
  logic            err;

  modport master (
    output byte_valid, byte_data, byte_last, clear, key_ready,
    input  byte_ready, key_valid, key_out, err
  );

  modport slave (
    input  byte_valid, byte_data, byte_last, clear, key_ready,
    output byte_ready, key_valid, key_out, err
  );

endinterface

// File: rtl/aes_key_pack.sv
// Collects key bytes MSB first into a 32*NK-bit word and hands it off over valid/ready.
module aes_key_pack
  import aes_key_pack_pkg::*;
#(
  parameter int NK = Nk
) (
  input  logic           clock,
  input  logic           reset,
  aes_key_pack_if.slave  kp
);

  localparam int NB = 4 * NK;
  localparam int KW = 32 * NK;
  localparam int CW = $clog2(NB);

  key_pack_state_t state_reg;
  logic [CW-1:0]   count_reg;
  logic [KW-1:0]   sr_reg;
  logic            byte_ready_reg;
  logic            key_valid_reg;
  logic            err_reg;

  assign kp.byte_ready = byte_ready_reg;
  assign kp.key_valid  = key_valid_reg;
  assign kp.key_out    = sr_reg;
  assign kp.err        = err_reg;

  always_ff @(posedge clock) begin
    // clear shares the reset path so it wins over any byte or key transfer
    if (reset || kp.clear) begin
      state_reg      <= IDLE;
      count_reg      <= '0;
      sr_reg         <= '0;
      byte_ready_reg <= 1'b1;
      key_valid_reg  <= 1'b0;
      err_reg        <= 1'b0;
    end else begin
      err_reg <= 1'b0;
      case (state_reg)
        IDLE, COLLECT: begin
          if (kp.byte_valid) begin
            if (count_reg == CW'(NB - 1)) begin
              // byte_last is irrelevant here: the length is fixed by NK
              sr_reg         <= {sr_reg[KW-9:0], kp.byte_data};
              count_reg      <= '0;
              state_reg      <= FULL;
              byte_ready_reg <= 1'b0;
              key_valid_reg  <= 1'b1;
            end else if (kp.byte_last) begin
              sr_reg    <= '0;
              count_reg <= '0;
              state_reg <= IDLE;
              err_reg   <= 1'b1;
            end else begin
              sr_reg    <= {sr_reg[KW-9:0], kp.byte_data};
              count_reg <= count_reg + 1'b1;
              state_reg <= COLLECT;
            end
          end
        end
        FULL: begin
          if (kp.key_ready) begin
            sr_reg         <= '0;
            count_reg      <= '0;
            state_reg      <= IDLE;
            byte_ready_reg <= 1'b1;
            key_valid_reg  <= 1'b0;
          end
        end
        default: begin
          state_reg      <= IDLE;
          count_reg      <= '0;
          sr_reg         <= '0;
          byte_ready_reg <= 1'b1;
          key_valid_reg  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aes_key_pack.sv
// Randomized bench for aes_key_pack at NK=4/6/8 against a byte-placement reference model.
module tb_aes_key_pack;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clock = ~clock;

  aes_key_pack_if #(.NK(4)) kp4 ();
  aes_key_pack_if #(.NK(6)) kp6 ();
  aes_key_pack_if #(.NK(8)) kp8 ();

  aes_key_pack #(.NK(4)) dut4 (.clock(clock), .reset(reset), .kp(kp4));
  aes_key_pack #(.NK(6)) dut6 (.clock(clock), .reset(reset), .kp(kp6));
  aes_key_pack #(.NK(8)) dut8 (.clock(clock), .reset(reset), .kp(kp8));

  // Reference: byte i of the stream lands at bits [8*(nb-1-i) +: 8]
  function automatic logic [255:0] model_pack(input logic [7:0] q[$], input int nb);
    logic [255:0] k;
    k = '0;
    for (int i = 0; i < nb; i++) k[8*(nb-1-i) +: 8] = q[i];
    return k;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic rand_bytes(output logic [7:0] q[$], input int n);
    q.delete();
    for (int i = 0; i < n; i++) q.push_back(8'($urandom));
  endtask

  // Sends one 16-byte key to the NK=4 instance, stalls the consumer, then hands off.
  task automatic stream4(input logic [7:0] q[$], input logic [127:0] exp_key, input int stall,
                         input bit mark_last, input int gap_pct, input string tag);
    for (int i = 0; i < 16; i++) begin
      while ($urandom_range(0, 99) < gap_pct) begin
        kp4.byte_valid = 1'b0;
        kp4.byte_last  = 1'b0;
        tick();
      end
      kp4.byte_valid = 1'b1;
      kp4.byte_data  = q[i];
      kp4.byte_last  = mark_last && (i == 15);
      vectors++;
      if (kp4.byte_ready !== 1'b1 || kp4.err !== 1'b0 || kp4.key_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL %s accept byte %0d: ready/err/kvalid=%b/%b/%b required 1/0/0",
                 tag, i, kp4.byte_ready, kp4.err, kp4.key_valid);
      end
      tick();
    end
    kp4.byte_last = 1'b0;
    kp4.byte_valid = 1'b0;
    kp4.key_ready = (stall == 0);
    for (int s = 0; s <= stall; s++) begin
      if (s == stall) kp4.key_ready = 1'b1;
      vectors++;
      if (kp4.key_valid !== 1'b1 || kp4.key_out !== exp_key || kp4.byte_ready !== 1'b0 ||
          kp4.err !== 1'b0) begin
        miscompares++;
        $display("FAIL %s full cycle %0d: kvalid=%b ready=%b err=%b key=%h required 1/0/0 key=%h",
                 tag, s, kp4.key_valid, kp4.byte_ready, kp4.err, kp4.key_out, exp_key);
      end
      // a back-pressured byte must be ignored through the handoff cycle
      kp4.byte_valid = (stall > 0);
      kp4.byte_data  = 8'($urandom);
      tick();
    end
    kp4.byte_valid = 1'b0;
    kp4.key_ready  = 1'b0;
    vectors++;
    if (kp4.key_valid !== 1'b0 || kp4.byte_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL %s after handoff: kvalid=%b ready=%b required 0/1", tag, kp4.key_valid,
               kp4.byte_ready);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    vectors++;
    if (kp4.byte_ready !== 1'b1 || kp4.key_valid !== 1'b0 || kp4.key_out !== '0 ||
        kp4.err !== 1'b0 || kp8.byte_ready !== 1'b1 || kp8.key_out !== '0) begin
      miscompares++;
      $display("FAIL reset: ready=%b kvalid=%b err=%b key=%h required 1/0/0 key=0",
               kp4.byte_ready, kp4.key_valid, kp4.err, kp4.key_out);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_fips();
    logic [7:0] q[$];
    q = '{8'h2b, 8'h7e, 8'h15, 8'h16, 8'h28, 8'hae, 8'hd2, 8'ha6,
          8'hab, 8'hf7, 8'h15, 8'h88, 8'h09, 8'hcf, 8'h4f, 8'h3c};
    stream4(q, 128'h2b7e151628aed2a6abf7158809cf4f3c, 0, 1'b1, 0, "fips");
  endtask

  task automatic test_stall();
    logic [7:0] q[$];
    logic [255:0] k;
    rand_bytes(q, 16);
    k = model_pack(q, 16);
    stream4(q, k[127:0], 5, 1'b1, 0, "stall");
    rand_bytes(q, 16);
    k = model_pack(q, 16);
    stream4(q, k[127:0], 0, 1'b1, 0, "after_stall");
  endtask

  task automatic test_early_last();
    logic [7:0] q[$];
    logic [255:0] k;
    for (int i = 0; i < 7; i++) begin
      kp4.byte_valid = 1'b1;
      kp4.byte_data  = 8'($urandom);
      kp4.byte_last  = (i == 6);
      tick();
    end
    kp4.byte_valid = 1'b0;
    kp4.byte_last  = 1'b0;
    vectors++;
    if (kp4.err !== 1'b1 || kp4.key_valid !== 1'b0 || kp4.byte_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL early_last pulse: err=%b kvalid=%b ready=%b required 1/0/1", kp4.err,
               kp4.key_valid, kp4.byte_ready);
    end
    tick();
    vectors++;
    if (kp4.err !== 1'b0 || kp4.key_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL early_last width: err=%b kvalid=%b required 0/0", kp4.err, kp4.key_valid);
    end
    rand_bytes(q, 16);
    k = model_pack(q, 16);
    stream4(q, k[127:0], 1, 1'b1, 0, "early_last_next");
  endtask

  task automatic test_clear();
    logic [7:0] q[$];
    logic [255:0] k;
    for (int i = 0; i < 9; i++) begin
      kp4.byte_valid = 1'b1;
      kp4.byte_data  = 8'($urandom);
      tick();
    end
    kp4.clear     = 1'b1;
    kp4.byte_data = 8'($urandom);
    kp4.byte_last = 1'b1;
    tick();
    kp4.clear      = 1'b0;
    kp4.byte_valid = 1'b0;
    kp4.byte_last  = 1'b0;
    vectors++;
    if (kp4.err !== 1'b0 || kp4.key_valid !== 1'b0 || kp4.byte_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL clear: err=%b kvalid=%b ready=%b required 0/0/1", kp4.err, kp4.key_valid,
               kp4.byte_ready);
    end
    rand_bytes(q, 16);
    k = model_pack(q, 16);
    stream4(q, k[127:0], 0, 1'b0, 0, "clear_next");
  endtask

  task automatic test_random();
    logic [7:0] q[$];
    logic [255:0] k;
    for (int n = 0; n < 10; n++) begin
      rand_bytes(q, 16);
      k = model_pack(q, 16);
      stream4(q, k[127:0], int'($urandom_range(0, 3)), 1'($urandom), 25, "random");
    end
  endtask

  task automatic test_nk8();
    for (int i = 0; i < 32; i++) begin
      kp8.byte_valid = 1'b1;
      kp8.byte_data  = 8'(i);
      kp8.byte_last  = (i == 31);
      tick();
    end
    kp8.byte_valid = 1'b0;
    kp8.byte_last  = 1'b0;
    kp8.key_ready  = 1'b1;
    vectors++;
    if (kp8.key_valid !== 1'b1 ||
        kp8.key_out !== 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f) begin
      miscompares++;
      $display("FAIL nk8 key: kvalid=%b key=%h required 1 key=000102..1f", kp8.key_valid,
               kp8.key_out);
    end
    tick();
    kp8.key_ready = 1'b0;
    vectors++;
    if (kp8.key_valid !== 1'b0 || kp8.byte_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL nk8 handoff: kvalid=%b ready=%b required 0/1", kp8.key_valid, kp8.byte_ready);
    end
  endtask

  task automatic test_nk6();
    logic [7:0] q[$];
    logic [255:0] k;
    rand_bytes(q, 24);
    k = model_pack(q, 24);
    for (int i = 0; i < 24; i++) begin
      kp6.byte_valid = 1'b1;
      kp6.byte_data  = q[i];
      tick();
    end
    kp6.byte_valid = 1'b0;
    vectors++;
    if (kp6.key_valid !== 1'b1 || kp6.key_out !== k[191:0] || kp6.key_out[191:184] !== q[0] ||
        kp6.err !== 1'b0) begin
      miscompares++;
      $display("FAIL nk6 key: kvalid=%b err=%b key=%h required 1/0 key=%h", kp6.key_valid,
               kp6.err, kp6.key_out, k[191:0]);
    end
    kp6.key_ready = 1'b1;
    tick();
    kp6.key_ready = 1'b0;
  endtask

  task automatic test_reset_in_full();
    for (int i = 0; i < 16; i++) begin
      kp4.byte_valid = 1'b1;
      kp4.byte_data  = 8'($urandom_range(1, 255));
      tick();
    end
    kp4.byte_valid = 1'b0;
    vectors++;
    if (kp4.key_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_full setup: kvalid=%b required 1", kp4.key_valid);
    end
    reset = 1'b1;
    tick();
    vectors++;
    if (kp4.key_valid !== 1'b0 || kp4.key_out !== '0 || kp4.byte_ready !== 1'b1 ||
        kp4.err !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_full: kvalid=%b ready=%b err=%b key=%h required 0/1/0 key=0",
               kp4.key_valid, kp4.byte_ready, kp4.err, kp4.key_out);
    end
    reset = 1'b0;
    tick();
  endtask

  initial begin
    kp4.byte_valid = 1'b0; kp4.byte_data = '0; kp4.byte_last = 1'b0;
    kp4.clear = 1'b0; kp4.key_ready = 1'b0;
    kp6.byte_valid = 1'b0; kp6.byte_data = '0; kp6.byte_last = 1'b0;
    kp6.clear = 1'b0; kp6.key_ready = 1'b0;
    kp8.byte_valid = 1'b0; kp8.byte_data = '0; kp8.byte_last = 1'b0;
    kp8.clear = 1'b0; kp8.key_ready = 1'b0;
    test_reset();
    test_fips();
    test_stall();
    test_early_last();
    test_clear();
    test_random();
    test_nk8();
    test_nk6();
    test_reset_in_full();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
